pc_gen: RTL

Parametrised program-counter generator for the Otter core fetch stage. It replaces the fixed 32-bit PC with configurable width, reset vector and 2/4-byte stepping. It adds a valid/ready fetch handshake, redirect buffering while a fetch is stalled, target-misalignment checking, and an optional return-address stack (RAS). It sits between the control unit, which supplies `w_en`, `src_sel` and the targets, and instruction memory.

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_ras.sv | 63 ++++++
 rtl/pc_gen.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared src_sel codes and FSM encoding for the program-counter generator
package pc_pkg;

    localparam logic [2:0] PC_SRC_NEXT   = 3'd0;
    localparam logic [2:0] PC_SRC_JALR   = 3'd1;
    localparam logic [2:0] PC_SRC_BRANCH = 3'd2;
    localparam logic [2:0] PC_SRC_JAL    = 3'd3;
    localparam logic [2:0] PC_SRC_MTVEC  = 3'd4;
    localparam logic [2:0] PC_SRC_MEPC   = 3'd5;

    typedef enum logic {
        PC_BOOT = 1'b0,
        PC_RUN  = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; overwrites oldest entry when full
module pc_ras #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_top,
    output logic            o_valid
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;

    logic            w_empty;
    logic            w_full;
    logic            w_do_push;
    logic            w_do_replace;
    logic            w_do_pop;
    logic [PW-1:0]   w_ptr_inc;

    assign w_empty      = (r_cnt == '0);
    assign w_full       = (r_cnt == CW'(RAS_DEPTH));
    // push+pop on an empty stack degenerates to a plain push
    assign w_do_replace = i_push && i_pop && !w_empty;
    assign w_do_push    = i_push && !w_do_replace;
    assign w_do_pop     = i_pop && !i_push && !w_empty;
    assign w_ptr_inc    = r_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_ptr_inc] <= i_data;
        end else if (w_do_replace) begin
            r_mem[r_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_do_push) begin
            r_ptr <= w_ptr_inc;
            if (!w_full) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (w_do_pop) begin
            r_ptr <= r_ptr - 1'b1;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_top   = w_empty ? '0 : r_mem[r_ptr];
    assign o_valid = !w_empty;

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage PC generator with stall-buffered redirects
// Optional return-address stack built when PC_RAS_EN is defined.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     C_EXT     = 0,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            w_en,
    input  logic [2:0]      src_sel,
    input  logic [XLEN-1:0] jalr,
    input  logic [XLEN-1:0] branch,
    input  logic [XLEN-1:0] jal,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            is_compressed,
    input  logic            ras_push,
    input  logic            ras_pop,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] next_addr,
    output logic            misalign,
    output logic            bad_sel,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_valid
);

    pc_state_e       r_state;
    pc_state_e       w_state_nxt;
    logic            w_fetch_valid;

    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_pend_addr;
    logic            r_pend_valid;
    logic            r_misalign;
    logic            r_bad_sel;

    logic [XLEN-1:0] w_step;
    logic [XLEN-1:0] w_next;
    logic [XLEN-1:0] w_target;
    logic            w_check;
    logic            w_redirect;
    logic            w_unaligned;
    logic            w_req;
    logic            w_accept;
    logic            w_illegal;
    logic            w_stall;
    logic            w_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PC_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PC_BOOT: w_state_nxt = PC_RUN;
            PC_RUN:  w_state_nxt = PC_RUN;
            default: w_state_nxt = PC_BOOT;
        endcase
    end

    always_comb begin
        w_fetch_valid = 1'b0;
        if (r_state == PC_RUN) begin
            w_fetch_valid = 1'b1;
        end
    end

    assign w_step  = ((C_EXT != 0) && is_compressed) ? XLEN'(2) : XLEN'(4);
    assign w_next  = r_addr + w_step;
    assign w_stall = w_fetch_valid && !fetch_ready;
    assign w_hs    = w_fetch_valid && fetch_ready;

    always_comb begin
        w_target   = '0;
        w_check    = 1'b0;
        w_redirect = 1'b1;
        case (src_sel)
            PC_SRC_JALR:   begin w_target = {jalr[XLEN-1:1], 1'b0}; w_check = 1'b1; end
            PC_SRC_BRANCH: begin w_target = branch;                 w_check = 1'b1; end
            PC_SRC_JAL:    begin w_target = jal;                    w_check = 1'b1; end
            PC_SRC_MTVEC:  w_target = {mtvec[XLEN-1:2], 2'b00};
            PC_SRC_MEPC:   w_target = mepc;
            default:       w_redirect = 1'b0;
        endcase
    end

    assign w_unaligned = w_check && ((C_EXT != 0) ? w_target[0] : (w_target[1:0] != 2'b00));
    assign w_req       = w_en && w_redirect;
    assign w_accept    = w_req && !w_unaligned;
    assign w_illegal   = w_en && (src_sel[2:1] == 2'b11);

    // a stalled fetch must keep addr stable, so redirects park in r_pend_addr until the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= RESET_VEC;
            r_pend_addr  <= '0;
            r_pend_valid <= 1'b0;
            r_misalign   <= 1'b0;
            r_bad_sel    <= 1'b0;
        end else begin
            r_misalign <= w_req && w_unaligned;
            r_bad_sel  <= w_illegal;
            if (w_accept && w_stall) begin
                r_pend_addr  <= w_target;
                r_pend_valid <= 1'b1;
            end else if (w_accept) begin
                r_addr       <= w_target;
                r_pend_valid <= 1'b0;
            end else if (w_hs && r_pend_valid) begin
                r_addr       <= r_pend_addr;
                r_pend_valid <= 1'b0;
            end else if (w_hs && w_en && (src_sel == PC_SRC_NEXT)) begin
                r_addr <= w_next;
            end
        end
    end

    assign fetch_valid = w_fetch_valid;
    assign addr        = r_addr;
    assign next_addr   = w_next;
    assign misalign    = r_misalign;
    assign bad_sel     = r_bad_sel;

`ifdef PC_RAS_EN
    logic w_push;
    logic w_pop;
    logic w_unused;

    assign w_push   = w_accept && ras_push && ((src_sel == PC_SRC_JAL) || (src_sel == PC_SRC_JALR));
    assign w_pop    = w_accept && ras_pop && (src_sel == PC_SRC_JALR);
    assign w_unused = ^{jalr[0], mtvec[1:0]};

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_next),
        .o_top   (ras_top),
        .o_valid (ras_valid)
    );
`else
    logic w_unused;

    assign w_unused  = ^{jalr[0], mtvec[1:0], ras_push, ras_pop};
    assign ras_top   = '0;
    assign ras_valid = 1'b0;
`endif

endmodule
